text_tile_generator: RTL and testbench
======================================

Name: text_tile_generator

Overview:
- Parametrised text-mode character generator for the VGA path.
- Holds an H_CHARS x V_CHARS tile buffer of character codes, writable from a host port.
- Maps the current pixel_x/pixel_y to a font-ROM address {code, font row} and serialises the returned font word into a per-pixel on/off signal.
- Sits between the VGA sync generator and the external synchronous font ROM. Adds a relocatable text window, a write/clear handshake and a fixed, pipelined latency.

Parameters:
- H_CHARS, 80, characters per text row (1..128)
- V_CHARS, 30, text rows (1..64)
- ORIGIN_X, 0, first pixel column of the text window
- ORIGIN_Y, 0, first pixel row of the text window
- CODE_W, 7, character code width
- BLANK_CODE, 0, code written by clear and used outside the window
- Derived: ADDR_W = clog2(H_CHARS*V_CHARS). Glyph cell fixed at 8 px wide x 16 rows.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- video_on  in  1  visible-area flag from the sync generator
- pixel_x  in  10  current pixel column
- pixel_y  in  10  current pixel row
- wr_en  in  1  host write request (single-cycle)
- wr_col  in  7  target character column
- wr_row  in  6  target character row
- wr_code  in  CODE_W  character code to store
- clr_req  in  1  request to fill the buffer with BLANK_CODE
- font_word  in  8  font-ROM data; bit 7 = leftmost pixel; valid one cycle after rom_addr
- rom_addr  out  CODE_W+4  font-ROM address {code, font row}
- pixel_on  out  1  foreground pixel
- busy  out  1  clear in progress
- wr_ack  out  1  one-cycle pulse: write committed
- wr_err  out  1  one-cycle pulse: write rejected
- clr_done  out  1  one-cycle pulse: clear finished

Behaviour:
- Reset values:
  - rom_addr = {BLANK_CODE, 4'd0}
  - pixel_on = 0, wr_ack = 0, wr_err = 0, clr_done = 0
  - busy = 1; FSM = CLEAR with clear pointer 0, so the buffer is always initialised after reset.
- Reset asserted mid-clear or mid-write restarts the clear from address 0. Any write in flight is discarded with no ack.
- Display pipeline (inputs sampled at edge N):
  - N: compute dx = pixel_x-ORIGIN_X and dy = pixel_y-ORIGIN_Y. in_area = pixel_x>=ORIGIN_X & pixel_y>=ORIGIN_Y & dx[9:3]<H_CHARS & dy[9:4]<V_CHARS. Register tile address = dy[9:4]*H_CHARS+dx[9:3], along with dy[3:0], dx[2:0], in_area and video_on.
  - N+1: synchronous tile-buffer read.
  - N+2: rom_addr <= in_area ? {code, dy[3:0]} : {BLANK_CODE, dy[3:0]}.
  - N+3: font_word is valid from the external ROM.
  - N+4: pixel_on <= font_word[7-dx[2:0]] & in_area & video_on, with all side signals delayed to match.
- Latency: rom_addr follows the pixel by 2 cycles; pixel_on by 4 cycles. The pipeline runs every cycle regardless of video_on.
- FSM states and transitions:
  - IDLE: busy = 0.
  - IDLE -> CLEAR on clr_req. clr_req has priority over a simultaneous wr_en; that write is dropped with no ack and no err.
  - CLEAR: writes BLANK_CODE at pointer p, p increments by 1 each cycle. busy = 1. clr_req is ignored. wr_en is dropped silently (no ack, no err).
  - CLEAR -> IDLE after the write at p = H_CHARS*V_CHARS-1. clr_done pulses in the first IDLE cycle.
- Host write (IDLE only):
  - wr_col>=H_CHARS or wr_row>=V_CHARS: no write; wr_err pulses at N+1.
  - Otherwise the write commits at edge N and wr_ack pulses at N+1.
  - Back-to-back writes are accepted every cycle.
- Read/write collision: the display read and the host write use separate RAM ports. On the same address in the same cycle, the read returns the old data.
- Address arithmetic is unsigned. A pixel left of or above the origin is out of area; no wrap-around.

Test Plan:
- Reset clear: H_CHARS=4, V_CHARS=2. Release reset -> busy=1 for exactly 8 cycles, clr_done pulses once, busy=0 afterwards. Every cell reads BLANK_CODE: rom_addr[10:4]=0 across the window.
- Write and fetch: write 0x41 at col 1, row 0 -> wr_ack at +1. Drive pixel_x=ORIGIN_X+8, pixel_y=ORIGIN_Y+3 -> rom_addr=0x413 two cycles later.
- Pixel serialisation: font_word=8'b1010_0000 with pixel_x stepping ORIGIN_X+8..+15 -> pixel_on sequence 1,0,1,0,0,0,0,0, delayed 4 cycles. With video_on=0 -> all zeros.
- Window boundary: ORIGIN_X=16. pixel_x=15 -> in_area=0, rom_addr code=BLANK_CODE, pixel_on=0. pixel_x=16+8*H_CHARS -> out of area.
- Rejects: wr_col=H_CHARS -> wr_err pulse, cell unchanged. wr_en during CLEAR -> no ack/err, cell = BLANK_CODE after clr_done. wr_en together with clr_req in IDLE -> clear starts, write lost.
- Reset mid-clear: assert reset at p=3 -> busy stays 1, full 8-cycle clear restarts from 0, exactly one clr_done.

Source files
------------

// File: rtl/text_tile_generator.sv
// text_tile_generator: tile-buffer text mode pixel generator (pixel -> font-ROM address -> pixel_on, 4-cycle latency) with host write/clear FSM
module text_tile_generator #(
  parameter int H_CHARS = 80,
  parameter int V_CHARS = 30,
  parameter int ORIGIN_X = 0,
  parameter int ORIGIN_Y = 0,
  parameter int CODE_W = 7,
  parameter logic [CODE_W-1:0] BLANK_CODE = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              video_on,
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  input  logic              wr_en,
  input  logic [6:0]        wr_col,
  input  logic [5:0]        wr_row,
  input  logic [CODE_W-1:0] wr_code,
  input  logic              clr_req,
  input  logic [7:0]        font_word,
  output logic [CODE_W+3:0] rom_addr,
  output logic              pixel_on,
  output logic              busy,
  output logic              wr_ack,
  output logic              wr_err,
  output logic              clr_done
);
  localparam int DEPTH = H_CHARS * V_CHARS;
  localparam int ADDR_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [9:0] OX = 10'(ORIGIN_X);
  localparam logic [9:0] OY = 10'(ORIGIN_Y);
  localparam logic [ADDR_W-1:0] HC = ADDR_W'(H_CHARS);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state;
  logic [ADDR_W-1:0] p, rd_addr, s0_addr, waddr;
  logic [CODE_W-1:0] mem [DEPTH];
  logic [CODE_W-1:0] rd_data, wdata;
  logic [9:0] dx, dy;
  logic in_area, wr_ok, we;
  logic [3:0] row0, row1, in_d, von_d;
  logic [3:0][2:0] col_d;
  assign dx = pixel_x - OX;
  assign dy = pixel_y - OY;
  assign in_area = pixel_x >= OX && pixel_y >= OY && 32'(dx[9:3]) < H_CHARS && 32'(dy[9:4]) < V_CHARS;
  assign rd_addr = in_area ? ADDR_W'(dy[9:4]) * HC + ADDR_W'(dx[9:3]) : '0;
  assign wr_ok = 32'(wr_col) < H_CHARS && 32'(wr_row) < V_CHARS;
  assign we = !reset && (state == CLEAR || (!clr_req && wr_en && wr_ok));
  assign waddr = state == CLEAR ? p : ADDR_W'(wr_row) * HC + ADDR_W'(wr_col);
  assign wdata = state == CLEAR ? BLANK_CODE : wr_code;
  assign busy = state == CLEAR;
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rd_data <= mem[s0_addr];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      s0_addr <= '0;
      row0 <= '0;
      row1 <= '0;
      col_d <= '0;
      in_d <= '0;
      von_d <= '0;
      rom_addr <= {BLANK_CODE, 4'd0};
      pixel_on <= 1'b0;
    end else begin
      s0_addr <= rd_addr;
      row0 <= dy[3:0];
      row1 <= row0;
      col_d <= {col_d[2:0], dx[2:0]};
      in_d <= {in_d[2:0], in_area};
      von_d <= {von_d[2:0], video_on};
      rom_addr <= {in_d[1] ? rd_data : BLANK_CODE, row1};
      pixel_on <= font_word[3'd7 - col_d[3]] & in_d[3] & von_d[3];
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      p <= '0;
      wr_ack <= 1'b0;
      wr_err <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      wr_ack <= 1'b0;
      wr_err <= 1'b0;
      clr_done <= 1'b0;
      if (state == CLEAR) begin
        p <= p == LAST ? '0 : p + 1'b1;
        state <= p == LAST ? IDLE : CLEAR;
        clr_done <= p == LAST;
      end else if (clr_req) begin
        state <= CLEAR;
        p <= '0;
      end else if (wr_en) begin
        wr_ack <= wr_ok;
        wr_err <= !wr_ok;
      end
    end
  end
endmodule

// File: tb/tb_text_tile_generator.sv
// tb_text_tile_generator: table vectors, hand sequences and randomized checks against a tile-level model
module tb_text_tile_generator;
  localparam int H = 4, V = 2, OX = 16, OY = 32;
  logic clk = 0, reset = 1, video_on = 0, wr_en = 0, clr_req = 0;
  logic [9:0] pixel_x = 0, pixel_y = 0;
  logic [6:0] wr_col = 0, wr_code = 0;
  logic [5:0] wr_row = 0;
  logic [7:0] font_word = 0;
  logic [10:0] rom_addr;
  logic pixel_on, busy, wr_ack, wr_err, clr_done;
  bit fixed_font = 0;
  int total = 0, bad = 0, hk = 0;
  logic [6:0] mm [8];
  logic [10:0] h_rom [1024];
  logic h_on [1024];
  bit h_v [1024];
  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic von;
    logic [10:0] rom;
    logic on;
  } vec_t;
  vec_t tv [16];
  text_tile_generator #(.H_CHARS(H), .V_CHARS(V), .ORIGIN_X(OX), .ORIGIN_Y(OY), .CODE_W(7), .BLANK_CODE(7'd0)) dut (
    .clk(clk), .reset(reset), .video_on(video_on), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .wr_en(wr_en), .wr_col(wr_col), .wr_row(wr_row), .wr_code(wr_code), .clr_req(clr_req),
    .font_word(font_word), .rom_addr(rom_addr), .pixel_on(pixel_on), .busy(busy),
    .wr_ack(wr_ack), .wr_err(wr_err), .clr_done(clr_done)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] rom_f(input logic [10:0] a);
    return 8'(a * 11'd173) ^ a[10:3];
  endfunction
  always @(posedge clk) font_word <= fixed_font ? 8'hA0 : rom_f(rom_addr);
  function automatic bit in_win(input int x, input int y);
    return x >= OX && y >= OY && (x - OX) / 8 < H && (y - OY) / 16 < V;
  endfunction
  function automatic logic [10:0] exp_rom(input int x, input int y);
    logic [6:0] c;
    c = in_win(x, y) ? mm[((y - OY) / 16) * H + (x - OX) / 8] : 7'd0;
    return {c, 4'((y - OY) & 15)};
  endfunction
  function automatic logic exp_on(input int x, input int y, input logic von);
    logic [7:0] f;
    f = fixed_font ? 8'hA0 : rom_f(exp_rom(x, y));
    return in_win(x, y) && von && f[7 - ((x - OX) & 7)];
  endfunction
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask
  task automatic step(input logic [9:0] x, input logic [9:0] y, input logic von, input logic [10:0] er, input logic eon, input bit v);
    @(negedge clk);
    if (hk >= 3 && h_v[hk-3]) chk($sformatf("rom_addr vec%0d", hk - 3), 32'(rom_addr), 32'(h_rom[hk-3]));
    if (hk >= 5 && h_v[hk-5]) chk($sformatf("pixel_on vec%0d", hk - 5), 32'(pixel_on), 32'(h_on[hk-5]));
    h_rom[hk] = er;
    h_on[hk] = eon;
    h_v[hk] = v;
    hk++;
    pixel_x = x;
    pixel_y = y;
    video_on = von;
  endtask
  task automatic drain();
    repeat (5) step(10'd0, 10'd0, 1'b0, 11'd0, 1'b0, 1'b0);
  endtask
  task automatic rand_disp(input int n);
    logic [9:0] x, y;
    logic von;
    hk = 0;
    repeat (n) begin
      x = ($urandom_range(0, 7) == 0) ? 10'($urandom) : 10'($urandom_range(0, 63));
      y = ($urandom_range(0, 7) == 0) ? 10'($urandom) : 10'($urandom_range(0, 79));
      von = $urandom_range(0, 3) != 0;
      step(x, y, von, exp_rom(int'(x), int'(y)), exp_on(int'(x), int'(y), von), 1'b1);
    end
    drain();
  endtask
  task automatic do_write(input int col, input int row, input logic [6:0] code);
    bit ok;
    ok = col < H && row < V;
    wr_en = 1;
    wr_col = 7'(col);
    wr_row = 6'(row);
    wr_code = code;
    @(negedge clk);
    chk($sformatf("wr_ack c%0d r%0d", col, row), 32'(wr_ack), 32'(ok));
    chk($sformatf("wr_err c%0d r%0d", col, row), 32'(wr_err), 32'(!ok));
    if (ok) mm[row * H + col] = code;
    wr_en = 0;
  endtask
  task automatic count_clear(input string nm);
    int nb = 0, nd = 0, na = 0;
    for (int i = 0; i < 20; i++) begin
      nb += int'(busy);
      nd += int'(clr_done);
      na += int'(wr_ack | wr_err);
      @(negedge clk);
      wr_en = 0;
      clr_req = 0;
    end
    chk({nm, " busy cycles"}, 32'(nb), 32'd8);
    chk({nm, " clr_done pulses"}, 32'(nd), 32'd1);
    chk({nm, " ack/err pulses"}, 32'(na), 32'd0);
    chk({nm, " busy after"}, 32'(busy), 32'd0);
    for (int i = 0; i < 8; i++) mm[i] = 7'd0;
  endtask
  initial begin
    int nd0;
    tv[0] = '{10'd24, 10'd35, 1'b1, 11'h413, 1'b1};
    tv[1] = '{10'd25, 10'd35, 1'b1, 11'h413, 1'b0};
    tv[2] = '{10'd26, 10'd35, 1'b1, 11'h413, 1'b1};
    tv[3] = '{10'd27, 10'd35, 1'b1, 11'h413, 1'b0};
    tv[4] = '{10'd28, 10'd35, 1'b1, 11'h413, 1'b0};
    tv[5] = '{10'd29, 10'd35, 1'b1, 11'h413, 1'b0};
    tv[6] = '{10'd30, 10'd35, 1'b1, 11'h413, 1'b0};
    tv[7] = '{10'd31, 10'd35, 1'b1, 11'h413, 1'b0};
    tv[8] = '{10'd26, 10'd35, 1'b0, 11'h413, 1'b0};
    tv[9] = '{10'd15, 10'd35, 1'b1, 11'h003, 1'b0};
    tv[10] = '{10'd48, 10'd35, 1'b1, 11'h003, 1'b0};
    tv[11] = '{10'd16, 10'd32, 1'b1, 11'h000, 1'b1};
    tv[12] = '{10'd16, 10'd31, 1'b1, 11'h00F, 1'b0};
    tv[13] = '{10'd16, 10'd63, 1'b1, 11'h00F, 1'b1};
    tv[14] = '{10'd16, 10'd64, 1'b1, 11'h000, 1'b0};
    tv[15] = '{10'd1023, 10'd35, 1'b1, 11'h003, 1'b0};
    for (int i = 0; i < 8; i++) mm[i] = 7'd0;
    repeat (3) @(negedge clk);
    chk("reset rom_addr", 32'(rom_addr), 32'h000);
    chk("reset pixel_on", 32'(pixel_on), 32'd0);
    chk("reset busy", 32'(busy), 32'd1);
    chk("reset wr_ack", 32'(wr_ack), 32'd0);
    chk("reset wr_err", 32'(wr_err), 32'd0);
    chk("reset clr_done", 32'(clr_done), 32'd0);
    reset = 0;
    count_clear("reset clear");
    rand_disp(200);
    do_write(1, 0, 7'h41);
    do_write(4, 0, 7'h55);
    do_write(0, 2, 7'h66);
    do_write(3, 1, 7'h7F);
    fixed_font = 1;
    hk = 0;
    for (int i = 0; i < 16; i++) step(tv[i].x, tv[i].y, tv[i].von, tv[i].rom, tv[i].on, 1'b1);
    drain();
    fixed_font = 0;
    repeat (8) do_write($urandom_range(0, 5), $urandom_range(0, 2), 7'($urandom));
    rand_disp(300);
    clr_req = 1;
    @(negedge clk);
    clr_req = 0;
    wr_en = 1;
    wr_col = 7'd2;
    wr_row = 6'd1;
    wr_code = 7'h5A;
    count_clear("write during clear");
    rand_disp(100);
    do_write(2, 1, 7'h22);
    clr_req = 1;
    wr_en = 1;
    wr_col = 7'd3;
    wr_row = 6'd1;
    wr_code = 7'h33;
    @(negedge clk);
    count_clear("clr_req with write");
    rand_disp(100);
    do_write(0, 0, 7'h11);
    do_write(3, 1, 7'h22);
    clr_req = 1;
    @(negedge clk);
    clr_req = 0;
    nd0 = 0;
    repeat (3) begin
      @(negedge clk);
      nd0 += int'(clr_done);
    end
    chk("mid-clear busy", 32'(busy), 32'd1);
    chk("mid-clear no clr_done", 32'(nd0), 32'd0);
    reset = 1;
    @(negedge clk);
    reset = 0;
    count_clear("reset mid-clear");
    rand_disp(100);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
